// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with valid/ready output.
// Define UART_RX_PARITY_EN for an even-parity bit before the stop bit.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   rx              serial line (async, idles high)
//   data_out, valid word output, held until valid && ready
//   ready           consumer accept
//   busy            receiver not idle
//   frame_err       pulse: stop bit sampled 0
//   parity_err      pulse: even-parity mismatch (0 without parity)
//   overrun         pulse: good word dropped, previous undelivered
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  IDX_LAST = 4'(DATA_BITS - 1);

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_d;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ferr_q;
  logic                 oerr_q;
  logic                 done_q;
  logic                 stop_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
  logic                 par_bad_q;
`endif

  always_comb begin
    cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif

      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      // Completion runs one cycle after the stop sample; a good word
      // may load in the same cycle as a handshake of the old one.
      if (done_q) begin
        if (!stop_q) begin
          ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (par_bad_q) begin
          perr_q <= 1'b1;
`endif
        end else if (valid_q && !ready) begin
          oerr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          // Half-bit check re-centres all later samples mid-bit.
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            // Right shift: first bit ends in the LSB.
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 4'd1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s_q ^ (^shift_q);
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start is seen.
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            stop_q  <= rx_s_q;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = oerr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; pairs with the team's UART transmitter on the same link.
- Frame format: one start bit (0), DATA_BITS data bits LSB first, optional even-parity bit, one stop bit (1).
- Samples the asynchronous rx line at mid-bit using a per-bit clock-cycle counter.
- Delivers each good byte on a valid/ready output port; reports framing, parity and overrun errors as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (115200 baud at 50 MHz); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, asynchronous to clk, idles high.
- data_out  out  DATA_BITS  received word, LSB = first data bit on the line.
- valid  out  1  data_out holds an undelivered word.
- ready  in  1  consumer accepts the word when valid && ready.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- overrun  out  1  one-cycle pulse: a good frame arrived while valid was high.

Behaviour:
- Reset values:
  - data_out = 0; valid, busy, frame_err, parity_err, overrun = 0.
  - Both synchronizer flops = 1; state = IDLE; all counters = 0.
- Synchronizer: rx passes through 2 flops. All logic uses the second flop (rx_s), so there are 2 cycles of latency from a pin edge.
- Bit counter (clk_cnt):
  - 16 bits wide; counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 on each bit boundary and on every state entry.
- IDLE:
  - On the first cycle rx_s == 0, go to START; clk_cnt = 0.
- START:
  - When clk_cnt == CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - If rx_s == 0: go to DATA; clk_cnt = 0; bit_idx = 0. This aligns later samples to mid-bit.
  - If rx_s == 1: glitch; return to IDLE with no error.
- DATA:
  - When clk_cnt == CLKS_PER_BIT-1, shift rx_s into shift register position bit_idx.
  - After bit DATA_BITS-1, go to PARITY if enabled, otherwise STOP.
- PARITY:
  - Sample at clk_cnt == CLKS_PER_BIT-1.
  - Record mismatch if the sampled bit != XOR of received data bits (even parity).
- STOP:
  - Sample at clk_cnt == CLKS_PER_BIT-1, i.e. mid stop bit; return to IDLE in the same cycle.
  - This lets a start bit immediately following the stop bit be detected.
- Frame completion, registered on the cycle after the stop sample, in priority order:
  1. Stop bit == 0: pulse frame_err; discard the word. A parity mismatch is not also reported.
  2. Parity mismatch: pulse parity_err; discard the word.
  3. valid == 1 and no handshake this cycle: pulse overrun; discard the new word; data_out is unchanged.
  4. Otherwise: data_out <= word; valid <= 1.
- Output handshake:
  - valid falls on the cycle after valid && ready.
  - data_out is stable while valid is high.
  - If the handshake and a good completion occur in the same cycle, the new word loads and valid stays 1, with no overrun.
  - ready has no effect when valid == 0.
- Break or stuck-low line: after framing error, IDLE immediately re-arms on rx_s == 0. It yields repeated framing errors once per frame time until the line returns high.
- Asynchronous reset mid-frame: aborts the frame and clears all state. No error pulse is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state present; one even-parity bit is expected between the data bits and the stop bit; parity_err is live.
- Undefined: PARITY state absent; the frame is start + DATA_BITS + stop; parity_err is constant 0.

Test Plan:
- Sim config: CLKS_PER_BIT=16, DATA_BITS=8.
- Good frame: send 0xA5 with the correct parity bit (0) and stop bit 1, ready held 1 -> valid pulses 1 cycle with data_out=0xA5; no error pulses.
- Glitch: rx low for 5 cycles, then high -> busy returns to 0; no valid, no errors.
- Framing error: send 0x3C with stop bit 0, then line high -> frame_err one pulse; valid stays 0.
- Parity error (macro defined): send 0x01 with parity bit 0 -> parity_err one pulse; no valid. With the macro undefined, 0x01 is delivered.
- Overrun: send 0x11 then 0x22 back-to-back, ready=0 throughout -> data_out=0x11 and valid=1; overrun pulses once at the end of the second frame. Then ready=1 -> valid drops next cycle.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF -> all outputs 0. After release, the next frame 0x5A is received correctly.
